uart_rx_byte: RTL and testbench



---
 rtl/uart_rx_byte_if.sv | 25 ++
 rtl/uart_rx_byte.sv | 127 ++++++++++++
 tb/tb_uart_rx_byte.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_byte_if.sv
// Signal bundle between the serial line, the UART byte receiver and the PIO/status glue.
// The master side is the receiver; the slave side drives rxd and consumes the byte/status.
interface uart_rx_byte_if;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rxd,
    output rx_data,
    output rx_valid,
    output frame_err,
    output busy
  );

  modport slave (
    output rxd,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 serial receiver: synchronizes rxd, samples each bit at mid-period and holds
// the last good byte on rx_data with a one-cycle rx_valid strobe and a framing-error flag.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic           clk,
  input  logic           reset_n,
  uart_rx_byte_if.master bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             sync_q, rxs_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;

  logic half_tick;
  logic bit_tick;

  assign half_tick = (cnt_q == HALF_LAST);
  assign bit_tick  = (cnt_q == BIT_LAST);

  // Synchronizer flops reset high so a released reset never looks like a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sync_q      <= 1'b1;
      rxs_q       <= 1'b1;
      cnt_q       <= '0;
      idx_q       <= '0;
      sh_q        <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= bus.rxd;
      rxs_q       <= sync_q;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh_q        <= sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!rxs_q) state_d = START;
      START:     if (half_tick) state_d = rxs_q ? IDLE : DATA;
      DATA:      if (bit_tick && (idx_q == 3'd7)) state_d = STOP;
      STOP:      if (bit_tick) state_d = rxs_q ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rxs_q) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Leaving STOP at the mid-stop sample re-arms IDLE half a bit early for back-to-back frames.
  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sh_d        = sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = frame_err_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
      end
      START: begin
        cnt_d = cnt_q + CNT_ONE;
        if (half_tick) begin
          cnt_d = '0;
          idx_d = '0;
        end
      end
      DATA: begin
        cnt_d = cnt_q + CNT_ONE;
        if (bit_tick) begin
          cnt_d       = '0;
          sh_d[idx_q] = rxs_q;
          if (idx_q != 3'd7) idx_d = idx_q + 3'd1;
        end
      end
      STOP: begin
        cnt_d = cnt_q + CNT_ONE;
        if (bit_tick) begin
          cnt_d = '0;
          if (rxs_q) begin
            rx_data_d   = sh_q;
            rx_valid_d  = 1'b1;
            frame_err_d = 1'b0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      WAIT_HIGH: cnt_d = '0;
      default:   cnt_d = '0;
    endcase
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: drives 8N1 frames on rxd, scoreboards received bytes
// and checks timing, glitch rejection, framing errors, async reset and baud tolerance.
module tb_uart_rx_byte;

  localparam int C      = 434;
  localparam int H      = C / 2;
  localparam int C_LONG = 447;
  localparam int C_SHRT = 421;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  int   t_start;
  logic prev_valid;
  logic [7:0] exp_b;
  logic [7:0] sb_q[$];
  int         vcyc[$];

  uart_rx_byte_if u_if ();

  uart_rx_byte #(.CLKS_PER_BIT(C)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Caller must be #1 after a posedge; returns #1 after a posedge with rxd left at stop_v.
  task automatic send_frame(input logic [7:0] b, input int bc, input logic stop_v);
    logic [9:0] bits;
    bits = {stop_v, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      u_if.rxd = bits[i];
      repeat (bc) @(posedge clk);
      #1;
    end
    $display("frame 0x%02h sent (bit=%0d clks, stop=%0b) at cycle %0d", b, bc, stop_v, cyc);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge clk);
    check_eq("drain", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  initial prev_valid = 1'b0;

  always @(negedge clk) begin
    if (u_if.rx_valid) begin
      vcyc.push_back(cyc);
      check_eq("valid_width", 32'(prev_valid), 32'd0);
      check_eq("busy_at_valid", 32'(u_if.busy), 32'd0);
      check_eq("ferr_at_valid", 32'(u_if.frame_err), 32'd0);
      check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp_b = sb_q.pop_front();
        check_eq("rx_data", 32'(u_if.rx_data), 32'(exp_b));
        $display("rx_valid at cycle %0d: data 0x%02h expected 0x%02h", cyc, u_if.rx_data, exp_b);
      end
    end
    prev_valid = u_if.rx_valid;
  end

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset_n   = 1'b0;
    u_if.rxd  = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("rst_data", 32'(u_if.rx_data), 32'h00);
    check_eq("rst_valid", 32'(u_if.rx_valid), 32'd0);
    check_eq("rst_ferr", 32'(u_if.frame_err), 32'd0);
    check_eq("rst_busy", 32'(u_if.busy), 32'd0);
    align();
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Single frame with latency check against t0 + H + 9*C + 1 (t0 = drive + 2 sync cycles)
    vcyc.delete();
    sb_q.push_back(8'hA5);
    t_start = cyc;
    send_frame(8'hA5, C, 1'b1);
    wait_drain(1000);
    check_eq("a5_count", 32'(vcyc.size()), 32'd1);
    if (vcyc.size() > 0) check_eq("a5_latency", 32'(vcyc[0]), 32'(t_start + 2 + H + 9 * C + 1));
    repeat (500) @(posedge clk);
    #1;
    check_eq("a5_hold", 32'(u_if.rx_data), 32'hA5);
    check_eq("a5_ferr", 32'(u_if.frame_err), 32'd0);

    // Back-to-back frames
    vcyc.delete();
    sb_q.push_back(8'h00);
    sb_q.push_back(8'hFF);
    sb_q.push_back(8'h3C);
    send_frame(8'h00, C, 1'b1);
    send_frame(8'hFF, C, 1'b1);
    send_frame(8'h3C, C, 1'b1);
    wait_drain(1000);
    check_eq("b2b_count", 32'(vcyc.size()), 32'd3);
    if (vcyc.size() == 3) begin
      for (int i = 1; i < 3; i++) check_eq("b2b_spacing", 32'(vcyc[i] - vcyc[i-1]), 32'(10 * C));
    end
    check_eq("b2b_last", 32'(u_if.rx_data), 32'h3C);

    // Short low glitch must be rejected
    align();
    vcyc.delete();
    u_if.rxd = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check_eq("glitch_busy", 32'(u_if.busy), 32'd1);
    repeat (50) @(posedge clk);
    #1;
    u_if.rxd = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    check_eq("glitch_idle", 32'(u_if.busy), 32'd0);
    check_eq("glitch_novalid", 32'(vcyc.size()), 32'd0);
    check_eq("glitch_data", 32'(u_if.rx_data), 32'h3C);
    $display("glitch of 100 cycles applied at cycle %0d", cyc);

    // Framing error followed by a long break, then recovery
    sb_q.push_back(8'h11);
    send_frame(8'h11, C, 1'b1);
    wait_drain(1000);
    align();
    vcyc.delete();
    send_frame(8'h3C, C, 1'b0);
    check_eq("ferr_set", 32'(u_if.frame_err), 32'd1);
    check_eq("ferr_busy", 32'(u_if.busy), 32'd1);
    check_eq("ferr_data", 32'(u_if.rx_data), 32'h11);
    repeat (20 * C) @(posedge clk);
    #1;
    check_eq("break_busy", 32'(u_if.busy), 32'd1);
    check_eq("break_ferr", 32'(u_if.frame_err), 32'd1);
    check_eq("break_novalid", 32'(vcyc.size()), 32'd0);
    u_if.rxd = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_eq("break_release", 32'(u_if.busy), 32'd0);
    sb_q.push_back(8'h42);
    send_frame(8'h42, C, 1'b1);
    wait_drain(1000);
    check_eq("recover_data", 32'(u_if.rx_data), 32'h42);
    check_eq("recover_ferr", 32'(u_if.frame_err), 32'd0);

    // Asynchronous reset during bit 4, held until the line is idle again
    align();
    vcyc.delete();
    fork
      send_frame(8'h5A, C, 1'b1);
      begin
        repeat (5 * C + 100) @(posedge clk);
        #2;
        check_eq("pre_rst_busy", 32'(u_if.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("arst_data", 32'(u_if.rx_data), 32'h00);
        check_eq("arst_valid", 32'(u_if.rx_valid), 32'd0);
        check_eq("arst_ferr", 32'(u_if.frame_err), 32'd0);
        check_eq("arst_busy", 32'(u_if.busy), 32'd0);
      end
    join
    align();
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_eq("arst_novalid", 32'(vcyc.size()), 32'd0);
    sb_q.push_back(8'h5A);
    send_frame(8'h5A, C, 1'b1);
    wait_drain(1000);
    check_eq("arst_next", 32'(u_if.rx_data), 32'h5A);

    // Baud mismatch +3% then -3%
    align();
    vcyc.delete();
    sb_q.push_back(8'h96);
    send_frame(8'h96, C_LONG, 1'b1);
    wait_drain(1000);
    check_eq("slow_data", 32'(u_if.rx_data), 32'h96);
    check_eq("slow_ferr", 32'(u_if.frame_err), 32'd0);
    align();
    sb_q.push_back(8'h96);
    send_frame(8'h96, C_SHRT, 1'b1);
    wait_drain(1000);
    check_eq("fast_data", 32'(u_if.rx_data), 32'h96);
    check_eq("fast_ferr", 32'(u_if.frame_err), 32'd0);
    check_eq("baud_count", 32'(vcyc.size()), 32'd2);

    repeat (100) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
